// File: rtl/opc_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opc_intc_pkg
// Description : Shared definitions for the opc_intc interrupt controller:
//               register offsets, FSM state encoding and a lowest-set-bit
//               priority encode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package opc_intc_pkg;

    typedef logic [1:0] reg_addr_t;

    // Register map (CPU I/O space offsets)
    localparam reg_addr_t REG_PENDING = 2'd0;
    localparam reg_addr_t REG_MASK    = 2'd1;
    localparam reg_addr_t REG_EDGE    = 2'd2;
    localparam reg_addr_t REG_ACTIVE  = 2'd3;

    // Request FSM encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    // Index of the lowest set bit (bit 0 = highest priority); 0 when empty.
    function automatic int unsigned lowest_set(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : opc_prio_enc
// Description : Fixed-priority encoder; reports whether any bit is set and
//               the index of the lowest set bit.
// Ports       : vec   - input vector (WIDTH bits, WIDTH <= 32)
//               valid - at least one bit of vec is set
//               idx   - index of the lowest set bit (0 when valid=0)
// Revision    : 1.0 - initial release
// ============================================================================
module opc_prio_enc
    import opc_intc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [31:0] w_ext;

    assign w_ext = 32'(vec);
    assign valid = |vec;
    assign idx   = IDX_W'(lowest_set(w_ext));

endmodule
`default_nettype wire

// File: rtl/opc_intc.sv
`default_nettype none
// ============================================================================
// Module      : opc_intc
// Description : N-channel interrupt controller. Latches level/edge requests,
//               masks them, arbitrates by fixed priority with nesting and
//               presents one request plus vector address to the core.
// Ports       : clk, reset (sync, active high), clken (global enable)
//               irq_in              - raw peripheral requests
//               reg_sel/rnw/addr/wdata/rdata - CPU I/O register port
//               int_req/int_vec     - request and vector to the core
//               int_ack             - core entering its INT state
//               eoi                 - end of interrupt (RTI)
// Revision    : 1.0 - initial release
// ============================================================================
module opc_intc
    import opc_intc_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                ADDR_W     = 20,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(2),
    parameter int                VEC_STRIDE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clken,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               reg_sel,
    input  logic               reg_rnw,
    input  logic [1:0]         reg_addr,
    input  logic [DATA_W-1:0]  reg_wdata,
    output logic [DATA_W-1:0]  reg_rdata,
    output logic               int_req,
    output logic [ADDR_W-1:0]  int_vec,
    input  logic               int_ack,
    input  logic               eoi
);

    localparam int c_IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_active;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_grant;
    logic               r_req;
    logic [ADDR_W-1:0]  r_vec;

    logic               w_wr;
    logic [NUM_IRQ-1:0] w_wdata;
    logic [NUM_IRQ-1:0] w_sw_clr;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic               w_elig_valid;
    logic [c_IDX_W-1:0] w_elig_idx;
    logic               w_act_valid;
    logic [c_IDX_W-1:0] w_act_idx;
    logic               w_cand;
    logic               w_ack_fire;
    logic [NUM_IRQ-1:0] w_ack_bit;
    logic [NUM_IRQ-1:0] w_eoi_bit;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [NUM_IRQ-1:0] w_active_nxt;
    logic [ADDR_W-1:0]  w_vec;

    assign w_wr    = reg_sel & ~reg_rnw;
    assign w_wdata = reg_wdata[NUM_IRQ-1:0];

    // Register bits above NUM_IRQ carry no state.
    generate
        if (DATA_W > NUM_IRQ) begin : g_wdata_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^reg_wdata[DATA_W-1:NUM_IRQ];
        end
    endgenerate

    // Write-1-to-clear only reaches edge channels.
    assign w_sw_clr = (w_wr && reg_addr == REG_PENDING) ? (w_wdata & r_edge) : '0;
    assign w_rise   = irq_in & ~r_irq_prev;

    assign w_eligible = r_pending & r_mask;

    opc_prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(c_IDX_W)) u_enc_elig (
        .vec   (w_eligible),
        .valid (w_elig_valid),
        .idx   (w_elig_idx)
    );

    opc_prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(c_IDX_W)) u_enc_active (
        .vec   (r_active),
        .valid (w_act_valid),
        .idx   (w_act_idx)
    );

    // Nesting: only channels strictly above the highest-priority in-service
    // channel may interrupt.
    assign w_cand = w_elig_valid && (!w_act_valid || (w_elig_idx < w_act_idx));

    assign w_ack_fire = (r_state == REQ) && int_ack;
    assign w_ack_bit  = w_ack_fire ? (NUM_IRQ'(1) << r_grant) : '0;
    assign w_eoi_bit  = (eoi && w_act_valid) ? (NUM_IRQ'(1) << w_act_idx) : '0;

    // Edge channels: a new rising edge beats any clear in the same cycle.
    assign w_pending_nxt = (r_edge & (w_rise | (r_pending & ~(w_sw_clr | (w_ack_bit & r_edge)))))
                         | (~r_edge & irq_in);

    // EOI clears first, then the ack sets.
    assign w_active_nxt = (r_active & ~w_eoi_bit) | w_ack_bit;

    assign w_vec = VEC_BASE + ADDR_W'(w_elig_idx) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_active   <= '0;
            r_irq_prev <= '0;
            r_state    <= IDLE;
            r_grant    <= '0;
            r_req      <= 1'b0;
            r_vec      <= VEC_BASE;
        end else if (clken) begin
            r_irq_prev <= irq_in;
            r_pending  <= w_pending_nxt;
            r_active   <= w_active_nxt;
            if (w_wr && reg_addr == REG_MASK) begin
                r_mask <= w_wdata;
            end
            if (w_wr && reg_addr == REG_EDGE) begin
                r_edge <= w_wdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_cand) begin
                        r_grant <= w_elig_idx;
                        r_vec   <= w_vec;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                default: begin
                    // A higher-priority arrival does not preempt; only ack
                    // or loss of eligibility leaves REQ.
                    if (int_ack || !w_eligible[r_grant]) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_PENDING: reg_rdata[NUM_IRQ-1:0] = r_pending;
            REG_MASK:    reg_rdata[NUM_IRQ-1:0] = r_mask;
            REG_EDGE:    reg_rdata[NUM_IRQ-1:0] = r_edge;
            default:     reg_rdata[NUM_IRQ-1:0] = r_active;
        endcase
    end

    assign int_req = r_req;
    assign int_vec = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_opc_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_opc_intc
// Description : Self-checking bench for opc_intc: directed scenarios with
//               fixed expected values, then randomized traffic checked each
//               cycle against a behavioural channel-by-channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opc_intc;

    logic        clk;
    logic        reset;
    logic        clken;
    logic [7:0]  irq_in;
    logic        reg_sel;
    logic        reg_rnw;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        int_req;
    logic [19:0] int_vec;
    logic        int_ack;
    logic        eoi;

    int n_checks;
    int n_bad;

    // Behavioural model state
    bit [7:0]  m_pend, m_mask, m_edge, m_act, m_prev;
    bit        m_req;
    bit [19:0] m_vec;
    int        m_grant;

    opc_intc dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .irq_in    (irq_in),
        .reg_sel   (reg_sel),
        .reg_rnw   (reg_rnw),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .eoi       (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next model state from the current inputs and model state.
    task automatic model_step();
        bit [7:0] np, na, nm, ne;
        int lowact;
        int cand;
        bit wr;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_edge = '0; m_act = '0; m_prev = '0;
            m_req = 1'b0; m_vec = 20'h2; m_grant = 0;
            return;
        end
        if (!clken) return;
        wr = reg_sel && !reg_rnw;
        lowact = 8;
        for (int i = 7; i >= 0; i--) if (m_act[i]) lowact = i;
        cand = -1;
        for (int i = 0; i < 8; i++)
            if (cand < 0 && m_pend[i] && m_mask[i] && i < lowact) cand = i;
        np = m_pend; na = m_act; nm = m_mask; ne = m_edge;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                if (wr && reg_addr == 2'd0 && reg_wdata[i]) np[i] = 1'b0;
                if (m_req && int_ack && m_grant == i) np[i] = 1'b0;
                if (irq_in[i] && !m_prev[i]) np[i] = 1'b1;
            end else begin
                np[i] = irq_in[i];
            end
        end
        if (eoi && lowact < 8) na[lowact] = 1'b0;
        if (m_req && int_ack) na[m_grant] = 1'b1;
        if (wr && reg_addr == 2'd1) nm = reg_wdata[7:0];
        if (wr && reg_addr == 2'd2) ne = reg_wdata[7:0];
        if (!m_req) begin
            if (cand >= 0) begin
                m_req = 1'b1;
                m_grant = cand;
                m_vec = 20'(2 + 2 * cand);
            end
        end else if (int_ack) begin
            m_req = 1'b0;
        end else if (!(m_pend[m_grant] && m_mask[m_grant])) begin
            m_req = 1'b0;
        end
        m_pend = np; m_act = na; m_mask = nm; m_edge = ne; m_prev = irq_in;
    endtask

    // One clock: advance model, clock the DUT, clear one-cycle strobes.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        reg_sel = 1'b0;
        int_ack = 1'b0;
        eoi     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_sel = 1'b1; reg_rnw = 1'b0; reg_addr = a; reg_wdata = d;
        cyc();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_rnw = 1'b1; reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        n_checks++;
        if (int_req !== 1'b0 || int_vec !== 20'h2) begin
            n_bad++;
            $display("FAIL reset_out: int_req=%b int_vec=%h want 0/00002", int_req, int_vec);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %h want 00000000", a, d);
            end
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        wr(2'd1, 32'h01);
        irq_in = 8'h01;
        cyc();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h1 || int_req !== 1'b0) begin
            n_bad++;
            $display("FAIL level_pend: pending=%h int_req=%b want 1/0", d, int_req);
        end
        cyc();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 20'h2) begin
            n_bad++;
            $display("FAIL level_req: int_req=%b int_vec=%h want 1/00002", int_req, int_vec);
        end
        int_ack = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1 || int_req !== 1'b0) begin
            n_bad++;
            $display("FAIL level_ack: active=%h int_req=%b want 1/0", d, int_req);
        end
        irq_in = 8'h00;
        cyc();
        eoi = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL level_eoi: active=%h want 0", d);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h00);
        irq_in = 8'h24;
        cyc(); cyc();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 20'h6) begin
            n_bad++;
            $display("FAIL prio_vec: int_req=%b int_vec=%h want 1/00006", int_req, int_vec);
        end
        int_ack = 1'b1;
        cyc();
        cyc(); cyc(); cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h4 || int_req !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_nested_block: active=%h int_req=%b want 4/0", d, int_req);
        end
        rd(2'd0, d);
        n_checks++;
        if (d[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_pend5: pending=%h want bit5 set", d);
        end
        irq_in = 8'h00;
        cyc();
        eoi = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0 || int_req !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_cleanup: active=%h int_req=%b want 0/0", d, int_req);
        end
    endtask

    task automatic test_nesting();
        logic [31:0] d;
        irq_in = 8'h10;
        cyc(); cyc();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 20'hA) begin
            n_bad++;
            $display("FAIL nest_vec4: int_req=%b int_vec=%h want 1/0000a", int_req, int_vec);
        end
        int_ack = 1'b1;
        cyc();
        irq_in = 8'h02;
        cyc(); cyc();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 20'h4) begin
            n_bad++;
            $display("FAIL nest_vec1: int_req=%b int_vec=%h want 1/00004", int_req, int_vec);
        end
        int_ack = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h12) begin
            n_bad++;
            $display("FAIL nest_active: active=%h want 12", d);
        end
        irq_in = 8'h00;
        eoi = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h10) begin
            n_bad++;
            $display("FAIL nest_eoi1: active=%h want 10", d);
        end
        eoi = 1'b1;
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h0 || int_req !== 1'b0) begin
            n_bad++;
            $display("FAIL nest_eoi2: active=%h int_req=%b want 0/0", d, int_req);
        end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wr(2'd1, 32'h00);
        wr(2'd2, 32'h08);
        irq_in = 8'h08;
        cyc();
        irq_in = 8'h00;
        cyc();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h08) begin
            n_bad++;
            $display("FAIL edge_latch: pending=%h want 08", d);
        end
        wr(2'd0, 32'h08);
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL edge_w1c: pending=%h want 00", d);
        end
        irq_in = 8'h08;
        cyc();
        wr(2'd0, 32'h08);
        cyc(); cyc();
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_bad++;
            $display("FAIL edge_held: pending=%h want 00", d);
        end
        irq_in = 8'h00;
        cyc();
        irq_in = 8'h08;
        wr(2'd0, 32'h08);
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h08) begin
            n_bad++;
            $display("FAIL edge_set_wins: pending=%h want 08", d);
        end
        irq_in = 8'h00;
        wr(2'd0, 32'h08);
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h40);
        irq_in = 8'h40;
        cyc(); cyc();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 20'hE) begin
            n_bad++;
            $display("FAIL wd_req: int_req=%b int_vec=%h want 1/0000e", int_req, int_vec);
        end
        wr(2'd1, 32'h00);
        cyc();
        rd(2'd3, d);
        n_checks++;
        if (int_req !== 1'b0 || d !== 32'h0) begin
            n_bad++;
            $display("FAIL wd_drop: int_req=%b active=%h want 0/0", int_req, d);
        end
        irq_in = 8'h00;
        cyc();
    endtask

    task automatic test_clken_reset();
        logic [31:0] d;
        wr(2'd1, 32'h01);
        irq_in = 8'h01;
        cyc(); cyc();
        clken = 1'b0;
        for (int k = 0; k < 5; k++) begin
            int_ack = 1'b1;
            cyc();
            rd(2'd3, d);
            n_checks++;
            if (int_req !== 1'b1 || d !== 32'h0) begin
                n_bad++;
                $display("FAIL clken_hold: cyc=%0d int_req=%b active=%h want 1/0", k, int_req, d);
            end
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        clken = 1'b1;
        irq_in = 8'h00;
        n_checks++;
        if (int_req !== 1'b0 || int_vec !== 20'h2) begin
            n_bad++;
            $display("FAIL rst_mid_req: int_req=%b int_vec=%h want 0/00002", int_req, int_vec);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_bad++;
                $display("FAIL rst_mid_reg%0d: got %h want 00000000", a, d);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        bit [7:0] exp_r;
        for (int n = 0; n < 2000; n++) begin
            n_checks++;
            if (int_req !== m_req || (m_req && int_vec !== m_vec)) begin
                n_bad++;
                $display("FAIL rand_out: n=%0d int_req=%b int_vec=%h want %b/%h",
                         n, int_req, int_vec, m_req, m_vec);
            end
            for (int a = 0; a < 4; a++) begin
                rd(2'(a), d);
                case (a)
                    0: exp_r = m_pend;
                    1: exp_r = m_mask;
                    2: exp_r = m_edge;
                    default: exp_r = m_act;
                endcase
                n_checks++;
                if (d !== {24'h0, exp_r}) begin
                    n_bad++;
                    $display("FAIL rand_reg%0d: n=%0d got %h want %h", a, n, d, {24'h0, exp_r});
                end
            end
            irq_in    = 8'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            clken     = ($urandom_range(0, 9) != 0);
            int_ack   = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 7) == 0);
            reg_sel   = ($urandom_range(0, 4) == 0);
            reg_rnw   = ($urandom_range(0, 3) == 0);
            reg_addr  = 2'($urandom);
            reg_wdata = $urandom;
            cyc();
        end
        reset = 1'b0;
        clken = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        reset     = 1'b1;
        clken     = 1'b1;
        irq_in    = '0;
        reg_sel   = 1'b0;
        reg_rnw   = 1'b1;
        reg_addr  = '0;
        reg_wdata = '0;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        test_reset();
        test_level();
        test_priority();
        test_nesting();
        test_edge();
        test_withdraw();
        test_clken_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
